// File: rtl/csr_port_arb_pkg.sv
// Shared definitions for the CSR port arbiter: FSM encoding, CSR funct3
// opcodes and the CSR addresses the arbiter and its bench refer to.
package csr_port_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // funct3 encodings of the Zicsr instructions
  localparam logic [2:0] FNC_CSRRW  = 3'b001;
  localparam logic [2:0] FNC_CSRRS  = 3'b010;
  localparam logic [2:0] FNC_CSRRC  = 3'b011;
  localparam logic [2:0] FNC_CSRRWI = 3'b101;
  localparam logic [2:0] FNC_CSRRSI = 3'b110;
  localparam logic [2:0] FNC_CSRRCI = 3'b111;

  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_TOHOST   = 12'h51E;

endpackage

// File: rtl/csr_arb_starve_cnt.sv
// Starvation timer for the CSR port arbiter. It is a down-counter that is
// loaded with MAX on clr and steps down once per pipeline grant. When it
// reaches zero it stops there, and hit stays high until the next clr.
module csr_arb_starve_cnt #(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [7:0] MAX_C = 8'(MAX);

  logic [7:0] remain;

  // Load on clear, count down on each grant, and stop at the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain <= MAX_C;
    end else if (clr) begin
      remain <= MAX_C;
    end else if (inc && (remain != 8'd0)) begin
      remain <= remain - 8'd1;
    end
  end

  assign hit = (remain == 8'd0);

endmodule

// File: rtl/csr_port_arb.sv
// CSR port arbiter. It shares one CSR-file port between the EX-stage
// pipeline, which gets zero-latency pass-through, and a host/debug
// requester that uses valid/ready handshakes.
//
// Host accesses are slotted into cycles where the pipeline is idle.
// Optional macro CSR_ARB_STARVE_EN: when it is defined, a host request that
// has waited through HOST_TIMEOUT pipeline grants is forced onto the port.
// The forced access stalls the pipeline for one cycle.
//
// state | meaning
// IDLE  | ready to accept a host request
// PEND  | host request latched, waiting for a free (or forced) port slot
// RESP  | host response presented, waiting for h_rsp_ready
module csr_port_arb
  import csr_port_arb_pkg::*;
#(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned AWIDTH       = 12,
  parameter int unsigned HOST_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  input  logic              p_we,
  input  logic              p_rd,
  input  logic [AWIDTH-1:0] p_addr,
  input  logic [2:0]        p_func,
  input  logic [DWIDTH-1:0] p_wdata,
  output logic [DWIDTH-1:0] p_rdata,
  output logic              p_stall,
  input  logic              h_req_valid,
  output logic              h_req_ready,
  input  logic              h_we,
  input  logic [AWIDTH-1:0] h_addr,
  input  logic [DWIDTH-1:0] h_wdata,
  output logic              h_rsp_valid,
  input  logic              h_rsp_ready,
  output logic [DWIDTH-1:0] h_rdata,
  output logic              csr_we,
  output logic              csr_rd,
  output logic [AWIDTH-1:0] csr_addr,
  output logic [2:0]        csr_func,
  output logic [DWIDTH-1:0] csr_data_in,
  input  logic [DWIDTH-1:0] csr_data_out
);

  state_t              state, state_nxt;
  logic                hq_we;
  logic [AWIDTH-1:0]   hq_addr;
  logic [DWIDTH-1:0]   hq_wdata;
  logic                accept;
  logic                issue;
  logic                force_hit;

`ifdef CSR_ARB_STARVE_EN
  logic cnt_clr;
  logic cnt_inc;

  // Every pipeline grant made while the host waits in PEND counts toward the timeout.
  assign cnt_clr = accept;
  assign cnt_inc = (state == ST_PEND) && !issue;

  csr_arb_starve_cnt #(
    .MAX (HOST_TIMEOUT)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .hit (force_hit)
  );
`else
  localparam int unsigned timeout_unused = HOST_TIMEOUT;
  assign force_hit = 1'b0;
`endif

  // State register, host request latch and captured host read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hq_we    <= 1'b0;
      hq_addr  <= '0;
      hq_wdata <= '0;
      h_rdata  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        hq_we    <= h_we;
        hq_addr  <= h_addr;
        hq_wdata <= h_wdata;
      end
      if (issue) begin
        h_rdata <= csr_data_out;
      end
    end
  end

  // Next-state logic. A host request never issues in the cycle it is accepted.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (h_req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!p_valid || force_hit) begin
          issue     = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (h_rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // CSR port mux: the host slot when issuing, otherwise gated pipeline pass-through.
  always_comb begin
    csr_we      = 1'b0;
    csr_rd      = 1'b0;
    csr_addr    = '0;
    csr_func    = 3'b000;
    csr_data_in = '0;
    p_stall     = 1'b0;
    p_rdata     = csr_data_out;
    if (rst) begin
      p_rdata = '0;
    end else if (issue) begin
      csr_we      = hq_we;
      csr_rd      = ~hq_we;
      csr_addr    = hq_addr;
      csr_func    = FNC_CSRRW;
      csr_data_in = hq_wdata;
      p_stall     = p_valid;
      p_rdata     = '0;
    end else if (p_valid) begin
      csr_we      = p_we;
      csr_rd      = p_rd;
      csr_addr    = p_addr;
      csr_func    = p_func;
      csr_data_in = p_wdata;
    end
  end

  assign h_req_ready = !rst && (state == ST_IDLE);
  assign h_rsp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_csr_port_arb.sv
// Directed bench for csr_port_arb, which includes a small CSR-file model.
// The model reads combinationally and commits writes at the clock edge.
module tb_csr_port_arb;
  import csr_port_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        p_valid, p_we, p_rd;
  logic [11:0] p_addr;
  logic [2:0]  p_func;
  logic [31:0] p_wdata, p_rdata;
  logic        p_stall;
  logic        h_req_valid, h_req_ready, h_we;
  logic [11:0] h_addr;
  logic [31:0] h_wdata;
  logic        h_rsp_valid, h_rsp_ready;
  logic [31:0] h_rdata;
  logic        csr_we, csr_rd;
  logic [11:0] csr_addr;
  logic [2:0]  csr_func;
  logic [31:0] csr_data_in, csr_data_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] csr_mem [0:4095];

  csr_port_arb #(.DWIDTH(32), .AWIDTH(12), .HOST_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_we(p_we), .p_rd(p_rd), .p_addr(p_addr), .p_func(p_func),
    .p_wdata(p_wdata), .p_rdata(p_rdata), .p_stall(p_stall),
    .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_we(h_we),
    .h_addr(h_addr), .h_wdata(h_wdata), .h_rsp_valid(h_rsp_valid),
    .h_rsp_ready(h_rsp_ready), .h_rdata(h_rdata),
    .csr_we(csr_we), .csr_rd(csr_rd), .csr_addr(csr_addr), .csr_func(csr_func),
    .csr_data_in(csr_data_in), .csr_data_out(csr_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign csr_data_out = csr_mem[csr_addr];
  always @(posedge clk) if (csr_we) csr_mem[csr_addr] <= csr_data_in;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic v, input logic we, input logic rd,
                      input logic [11:0] a, input logic [31:0] d);
    p_valid = v; p_we = we; p_rd = rd; p_addr = a; p_wdata = d;
    p_func = we ? FNC_CSRRW : FNC_CSRRS;
  endtask

  task automatic host(input logic v, input logic we, input logic [11:0] a,
                      input logic [31:0] d);
    h_req_valid = v; h_we = we; h_addr = a; h_wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pipe(1'b1, 1'b1, 1'b0, CSR_TOHOST, 32'h1111_1111);
    host(1'b1, 1'b0, CSR_TOHOST, 32'h0);
    h_rsp_ready = 1'b0;
    #12;
    checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL reset_csr_we: got %b want 0", csr_we); end
    checks++; if (csr_addr !== 12'h0) begin errors++; $display("FAIL reset_csr_addr: got %h want 000", csr_addr); end
    checks++; if (csr_data_in !== 32'h0) begin errors++; $display("FAIL reset_csr_data_in: got %h want 0", csr_data_in); end
    checks++; if (p_stall !== 1'b0) begin errors++; $display("FAIL reset_p_stall: got %b want 0", p_stall); end
    checks++; if (h_req_ready !== 1'b0) begin errors++; $display("FAIL reset_h_req_ready: got %b want 0", h_req_ready); end
    checks++; if (h_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_h_rsp_valid: got %b want 0", h_rsp_valid); end
    checks++; if (h_rdata !== 32'h0) begin errors++; $display("FAIL reset_h_rdata: got %h want 0", h_rdata); end
    pipe(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    host(1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    checks++; if (h_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_h_req_ready: got %b want 1", h_req_ready); end
    tick();
  endtask

  task automatic test_pipe_only();
    pipe(1'b1, 1'b1, 1'b0, CSR_TOHOST, 32'hDEAD_BEEF);
    #1;
    checks++; if (csr_we !== 1'b1) begin errors++; $display("FAIL pipe_wr_csr_we: got %b want 1", csr_we); end
    checks++; if (csr_addr !== CSR_TOHOST) begin errors++; $display("FAIL pipe_wr_addr: got %h want 51e", csr_addr); end
    checks++; if (csr_data_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pipe_wr_data: got %h want deadbeef", csr_data_in); end
    checks++; if (csr_func !== FNC_CSRRW) begin errors++; $display("FAIL pipe_wr_func: got %b want 001", csr_func); end
    checks++; if (p_stall !== 1'b0) begin errors++; $display("FAIL pipe_wr_stall: got %b want 0", p_stall); end
    tick();
    pipe(1'b1, 1'b0, 1'b1, CSR_TOHOST, 32'h0);
    #1;
    checks++; if (csr_rd !== 1'b1 || csr_we !== 1'b0) begin errors++; $display("FAIL pipe_rd_strobes: got rd=%b we=%b want rd=1 we=0", csr_rd, csr_we); end
    checks++; if (p_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pipe_rd_data: got %h want deadbeef", p_rdata); end
    tick();
    pipe(1'b0, 1'b1, 1'b1, CSR_TOHOST, 32'h5555_5555);
    #1;
    checks++; if (csr_we !== 1'b0 || csr_rd !== 1'b0 || csr_addr !== 12'h0) begin errors++; $display("FAIL pipe_gate: got we=%b rd=%b addr=%h want 0 0 000", csr_we, csr_rd, csr_addr); end
    tick();
  endtask

  task automatic test_host_read();
    pipe(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    host(1'b1, 1'b0, CSR_TOHOST, 32'h0);
    h_rsp_ready = 1'b0;
    #1;
    checks++; if (h_req_ready !== 1'b1) begin errors++; $display("FAIL hrd_c0_ready: got %b want 1", h_req_ready); end
    checks++; if (csr_rd !== 1'b0) begin errors++; $display("FAIL hrd_c0_no_issue: got csr_rd=%b want 0", csr_rd); end
    tick();
    host(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    checks++; if (csr_rd !== 1'b1 || csr_we !== 1'b0) begin errors++; $display("FAIL hrd_c1_strobes: got rd=%b we=%b want 1 0", csr_rd, csr_we); end
    checks++; if (csr_addr !== CSR_TOHOST) begin errors++; $display("FAIL hrd_c1_addr: got %h want 51e", csr_addr); end
    checks++; if (csr_func !== FNC_CSRRW) begin errors++; $display("FAIL hrd_c1_func: got %b want 001", csr_func); end
    checks++; if (h_req_ready !== 1'b0 || h_rsp_valid !== 1'b0) begin errors++; $display("FAIL hrd_c1_hs: got ready=%b rsp=%b want 0 0", h_req_ready, h_rsp_valid); end
    tick();
    checks++; if (h_rsp_valid !== 1'b1) begin errors++; $display("FAIL hrd_c2_rsp_valid: got %b want 1", h_rsp_valid); end
    checks++; if (h_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hrd_c2_rdata: got %h want deadbeef", h_rdata); end
    h_rsp_ready = 1'b1;
    tick();
    h_rsp_ready = 1'b0;
    #1;
    checks++; if (h_rsp_valid !== 1'b0 || h_req_ready !== 1'b1) begin errors++; $display("FAIL hrd_done: got rsp=%b ready=%b want 0 1", h_rsp_valid, h_req_ready); end
  endtask

  task automatic test_backpressure();
    host(1'b1, 1'b1, CSR_TOHOST, 32'h1234_5678);
    pipe(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    host(1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    checks++; if (csr_we !== 1'b1 || csr_rd !== 1'b0) begin errors++; $display("FAIL hwr_strobes: got we=%b rd=%b want 1 0", csr_we, csr_rd); end
    checks++; if (csr_data_in !== 32'h1234_5678) begin errors++; $display("FAIL hwr_data: got %h want 12345678", csr_data_in); end
    tick();
    for (int i = 0; i < 3; i++) begin
      pipe(1'b1, 1'b0, 1'b1, CSR_TOHOST, 32'h0);
      #1;
      checks++; if (h_rsp_valid !== 1'b1 || h_req_ready !== 1'b0) begin errors++; $display("FAIL bp_hs[%0d]: got rsp=%b ready=%b want 1 0", i, h_rsp_valid, h_req_ready); end
      checks++; if (h_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_rdata[%0d]: got %h want deadbeef", i, h_rdata); end
      checks++; if (p_rdata !== 32'h1234_5678 || p_stall !== 1'b0 || csr_rd !== 1'b1) begin errors++; $display("FAIL bp_pipe[%0d]: got rdata=%h stall=%b rd=%b want 12345678 0 1", i, p_rdata, p_stall, csr_rd); end
      tick();
    end
    pipe(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    h_rsp_ready = 1'b1;
    host(1'b1, 1'b0, CSR_MSCRATCH, 32'h0);
    #1;
    checks++; if (h_req_ready !== 1'b0) begin errors++; $display("FAIL bp_release_ready: got %b want 0", h_req_ready); end
    tick();
    host(1'b0, 1'b0, 12'h0, 32'h0);
    h_rsp_ready = 1'b0;
    #1;
    checks++; if (h_rsp_valid !== 1'b0 || h_req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle: got rsp=%b ready=%b want 0 1", h_rsp_valid, h_req_ready); end
    tick();
    checks++; if (h_req_ready !== 1'b1 || csr_rd !== 1'b0) begin errors++; $display("FAIL bp_no_same_cycle_accept: got ready=%b rd=%b want 1 0", h_req_ready, csr_rd); end
  endtask

  task automatic test_simultaneous();
    pipe(1'b1, 1'b1, 1'b0, CSR_MSCRATCH, 32'hA5A5_0001);
    host(1'b1, 1'b0, CSR_MSCRATCH, 32'h0);
    #1;
    checks++; if (csr_we !== 1'b1 || csr_addr !== CSR_MSCRATCH || h_req_ready !== 1'b1) begin errors++; $display("FAIL sim_c0: got we=%b addr=%h ready=%b want 1 340 1", csr_we, csr_addr, h_req_ready); end
    tick();
    host(1'b0, 1'b0, 12'h0, 32'h0);
    pipe(1'b1, 1'b1, 1'b0, CSR_MSCRATCH, 32'h0000_0002);
    #1;
    checks++; if (csr_we !== 1'b1 || csr_data_in !== 32'h2 || p_stall !== 1'b0) begin errors++; $display("FAIL sim_c1: got we=%b data=%h stall=%b want 1 2 0", csr_we, csr_data_in, p_stall); end
    tick();
    pipe(1'b1, 1'b0, 1'b1, 12'h341, 32'h0);
    #1;
    checks++; if (csr_addr !== 12'h341 || p_stall !== 1'b0 || h_rsp_valid !== 1'b0) begin errors++; $display("FAIL sim_c2: got addr=%h stall=%b rsp=%b want 341 0 0", csr_addr, p_stall, h_rsp_valid); end
    tick();
    pipe(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    checks++; if (csr_rd !== 1'b1 || csr_addr !== CSR_MSCRATCH || p_stall !== 1'b0) begin errors++; $display("FAIL sim_issue: got rd=%b addr=%h stall=%b want 1 340 0", csr_rd, csr_addr, p_stall); end
    tick();
    checks++; if (h_rsp_valid !== 1'b1 || h_rdata !== 32'h2) begin errors++; $display("FAIL sim_rsp: got rsp=%b rdata=%h want 1 00000002", h_rsp_valid, h_rdata); end
    h_rsp_ready = 1'b1;
    tick();
    h_rsp_ready = 1'b0;
  endtask

  task automatic test_starve();
    int stalls;
    stalls = 0;
    h_rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pipe(1'b1, 1'b1, 1'b0, 12'h342, 32'(k));
      host(k == 0, 1'b0, CSR_TOHOST, 32'h0);
      #1;
      if (p_stall === 1'b1) stalls++;
`ifdef CSR_ARB_STARVE_EN
      checks++; if (p_stall !== (k == 5)) begin errors++; $display("FAIL starve_stall[%0d]: got %b want %b", k, p_stall, (k == 5)); end
      checks++; if (csr_addr !== ((k == 5) ? CSR_TOHOST : 12'h342)) begin errors++; $display("FAIL starve_addr[%0d]: got %h", k, csr_addr); end
      if (k == 5) begin
        checks++; if (csr_rd !== 1'b1 || csr_we !== 1'b0 || p_rdata !== 32'h0) begin errors++; $display("FAIL starve_issue: got rd=%b we=%b p_rdata=%h want 1 0 0", csr_rd, csr_we, p_rdata); end
      end
      if (k == 6) begin
        checks++; if (h_rsp_valid !== 1'b1 || h_rdata !== 32'h1234_5678) begin errors++; $display("FAIL starve_rsp: got rsp=%b rdata=%h want 1 12345678", h_rsp_valid, h_rdata); end
      end
`else
      checks++; if (p_stall !== 1'b0 || csr_addr !== 12'h342) begin errors++; $display("FAIL nostarve[%0d]: got stall=%b addr=%h want 0 342", k, p_stall, csr_addr); end
`endif
      tick();
    end
`ifdef CSR_ARB_STARVE_EN
    checks++; if (stalls != 1) begin errors++; $display("FAIL starve_stall_count: got %0d want 1", stalls); end
`else
    checks++; if (stalls != 0) begin errors++; $display("FAIL nostarve_stall_count: got %0d want 0", stalls); end
    pipe(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    #1;
    checks++; if (csr_rd !== 1'b1 || csr_addr !== CSR_TOHOST) begin errors++; $display("FAIL nostarve_issue: got rd=%b addr=%h want 1 51e", csr_rd, csr_addr); end
    tick();
    checks++; if (h_rsp_valid !== 1'b1 || h_rdata !== 32'h1234_5678) begin errors++; $display("FAIL nostarve_rsp: got rsp=%b rdata=%h want 1 12345678", h_rsp_valid, h_rdata); end
    tick();
`endif
    pipe(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    h_rsp_ready = 1'b0;
    #1;
    checks++; if (h_req_ready !== 1'b1) begin errors++; $display("FAIL starve_end_idle: got %b want 1", h_req_ready); end
    tick();
  endtask

  task automatic test_reset_mid();
    host(1'b1, 1'b0, CSR_TOHOST, 32'h0);
    pipe(1'b1, 1'b0, 1'b1, 12'h342, 32'h0);
    tick();
    host(1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    checks++; if (csr_we !== 1'b0 || csr_rd !== 1'b0 || csr_addr !== 12'h0) begin errors++; $display("FAIL rstmid_csr: got we=%b rd=%b addr=%h want 0 0 000", csr_we, csr_rd, csr_addr); end
    checks++; if (p_stall !== 1'b0 || h_rsp_valid !== 1'b0 || h_req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_hs: got stall=%b rsp=%b ready=%b want 0 0 0", p_stall, h_rsp_valid, h_req_ready); end
    #2;
    rst = 1'b0;
    pipe(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (csr_rd !== 1'b0 || csr_we !== 1'b0 || h_rsp_valid !== 1'b0 || h_req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_quiet[%0d]: got rd=%b we=%b rsp=%b ready=%b want 0 0 0 1", i, csr_rd, csr_we, h_rsp_valid, h_req_ready); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_host_read();
    test_backpressure();
    test_simultaneous();
    test_starve();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_port_arb.md
Name: csr_port_arb

Overview:
- Arbitrates the single CSR-file access port between two requesters:
  - the EX-stage pipeline, which needs zero-latency pass-through;
  - a host/debug requester (UART monitor), using valid/ready handshakes.
- Sits between the EX stage and the CSR file.
- Sequences host accesses into idle pipeline cycles. When a host request has waited too long, it stalls the pipeline for one cycle.

Parameters:
- DWIDTH, 32, CSR data width
- AWIDTH, 12, CSR address width
- HOST_TIMEOUT, 8, max pipeline grants while a host request is pending before the host is forced (needs CSR_ARB_STARVE_EN); legal range 1..255

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- p_valid  in  1  pipeline CSR access this cycle
- p_we  in  1  pipeline write enable
- p_rd  in  1  pipeline read enable
- p_addr  in  AWIDTH  pipeline CSR address
- p_func  in  3  pipeline funct3 (CSRRW/CSRRWI...)
- p_wdata  in  DWIDTH  pipeline write data
- p_rdata  out  DWIDTH  pipeline read data (combinational)
- p_stall  out  1  pipeline must hold the EX instruction this cycle
- h_req_valid  in  1  host request valid
- h_req_ready  out  1  arbiter can accept a host request
- h_we  in  1  host write enable
- h_addr  in  AWIDTH  host CSR address
- h_wdata  in  DWIDTH  host write data
- h_rsp_valid  out  1  host response valid
- h_rsp_ready  in  1  host accepts the response
- h_rdata  out  DWIDTH  host read data
- csr_we  out  1  to CSR file
- csr_rd  out  1  to CSR file
- csr_addr  out  AWIDTH  to CSR file
- csr_func  out  3  to CSR file
- csr_data_in  out  DWIDTH  to CSR file
- csr_data_out  in  DWIDTH  from CSR file; combinational read, write commits at clk edge

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; host request registers and starvation counter clear.
  - Outputs during and after reset: h_rsp_valid=0, h_rdata=0, p_stall=0, h_req_ready=0 while rst=1, all csr_* =0.
  - A pending or in-flight host request is dropped; the host must re-issue it.
- States: IDLE, PEND, RESP.
- Pipeline pass-through (any state where the host is not issuing):
  - csr_* = p_* gated by p_valid (csr_we=p_valid&p_we, csr_rd=p_valid&p_rd).
  - p_rdata=csr_data_out; p_stall=0; zero added latency.
- IDLE:
  - h_req_ready=1.
  - On h_req_valid: latch {h_we, h_addr, h_wdata} and go to PEND. The counter resets to 0.
  - A same-cycle p_valid is served normally.
- PEND:
  - h_req_ready=0.
  - Issue condition: p_valid=0, or counter==HOST_TIMEOUT.
  - On issue:
    - csr_* are driven from the latched host registers; csr_rd=~h_we; csr_func=FNC_CSRRW.
    - h_rdata <= csr_data_out.
    - p_stall=p_valid; p_rdata=0.
    - Next state RESP.
  - Otherwise the pipeline passes through and the counter increments, saturating at HOST_TIMEOUT.
- RESP:
  - h_rsp_valid=1, h_rdata held stable, h_req_ready=0; the pipeline passes through.
  - On h_rsp_ready: go to IDLE. A new host request may be accepted the next cycle, not in the same cycle.
- Host write response: h_rsp_valid asserts with h_rdata = the pre-write CSR value.
- The host never issues in the same cycle it is accepted. Host access latency is ≥2 cycles from h_req_valid&h_req_ready to h_rsp_valid.
- A stalled pipeline access is not performed; the pipeline re-presents it the next cycle.

Optional Feature:
- CSR_ARB_STARVE_EN
  - Defined: the starvation counter exists, and the host is forced after HOST_TIMEOUT pipeline grants in PEND, with p_stall=1 for exactly one cycle.
  - Undefined: no counter; the host issues only when p_valid=0, so p_stall is constant 0 and HOST_TIMEOUT is unused.

Decomposition:
- Shared package/header: state encoding localparams (IDLE/PEND/RESP), FNC_CSRRW and other funct3 codes (reuse the existing opcode header), CSR address constants used by the bench (tohost 0x51E).
- Sub-module: csr_arb_starve_cnt, a saturating counter with clear/inc/hit, instantiated only under CSR_ARB_STARVE_EN.

Test Plan:
- Pipeline only:
  - Stimulus: p_valid=1, p_we=1, p_addr=0x51E, p_wdata=0xDEADBEEF, no host request.
  - Response: csr_we=1, csr_addr=0x51E in the same cycle, p_stall=0; a following pipeline read returns p_rdata=0xDEADBEEF.
- Host read, pipeline idle:
  - Stimulus: h_req_valid with h_addr=0x51E.
  - Response: accepted in cycle 0; csr_rd=1, csr_addr=0x51E in cycle 1; h_rsp_valid=1 with h_rdata=0xDEADBEEF in cycle 2.
- Simultaneous requests:
  - Stimulus: p_valid and h_req_valid both asserted in IDLE.
  - Response: pipeline served, host latched; host issues in the first later cycle with p_valid=0; p_stall never asserts.
- Starvation (macro on, HOST_TIMEOUT=4):
  - Stimulus: p_valid held for 20 cycles with the host pending.
  - Response: exactly 4 pipeline grants, then one cycle with p_stall=1 and csr_addr=h_addr, then pipeline grants resume.
- Response backpressure:
  - Stimulus: h_rsp_ready=0 for 3 cycles.
  - Response: h_rsp_valid and h_rdata stable, h_req_ready=0, pipeline accesses unaffected; IDLE one cycle after h_rsp_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst while in PEND.
  - Response: immediately csr_*=0, p_stall=0, h_rsp_valid=0; after release, no host access occurs until a new request.
